// File: rtl/kitchen_countdown_core.sv
// Kitchen-timer core: prescales clk to a one-second enable and runs the MM:SS BCD countdown FSM.
// running/alarm are registered decodes of the state register, so they follow it by one cycle.
module kitchen_countdown_core #(
    parameter int TICK_DIV   = 50000000,
    parameter int ALARM_SECS = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       inc_min,
    input  logic       inc_sec,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       alarm,
    output logic       tick
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int AW = (ALARM_SECS > 1) ? $clog2(ALARM_SECS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [AW-1:0] ACNT_LAST  = AW'(ALARM_SECS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_ALARM = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [AW-1:0] acnt_q, acnt_d;
    logic [3:0]    mt_q, mt_d, mo_q, mo_d, st_q, st_d, so_q, so_d;
    logic          tick_q, tick_d;
    logic          running_q, running_d;
    logic          alarm_q, alarm_d;

    logic [3:0]    mt_inc, mo_inc, st_inc, so_inc;
    logic [3:0]    mt_dec, mo_dec, st_dec, so_dec;
    logic          time_zero, dec_zero, sec_boundary;

    // BCD +1 for the set buttons: seconds wrap 59->00 without touching minutes
    always_comb begin
        so_inc = so_q + 4'd1;
        st_inc = st_q;
        if (so_q >= 4'd9) begin
            so_inc = 4'd0;
            st_inc = (st_q >= 4'd5) ? 4'd0 : st_q + 4'd1;
        end
        mo_inc = mo_q + 4'd1;
        mt_inc = mt_q;
        if (mo_q >= 4'd9) begin
            mo_inc = 4'd0;
            mt_inc = (mt_q >= 4'd9) ? 4'd0 : mt_q + 4'd1;
        end
    end

    // BCD -1 across MM:SS; only used in RUN, where the time is never 00:00
    always_comb begin
        so_dec = so_q - 4'd1;
        st_dec = st_q;
        mo_dec = mo_q;
        mt_dec = mt_q;
        if (so_q == 4'd0) begin
            so_dec = 4'd9;
            st_dec = st_q - 4'd1;
            if (st_q == 4'd0) begin
                st_dec = 4'd5;
                mo_dec = mo_q - 4'd1;
                if (mo_q == 4'd0) begin
                    mo_dec = 4'd9;
                    mt_dec = mt_q - 4'd1;
                end
            end
        end
    end

    assign time_zero    = ({mt_q, mo_q, st_q, so_q} == 16'h0000);
    assign dec_zero     = ({mt_dec, mo_dec, st_dec, so_dec} == 16'h0000);
    assign sec_boundary = (presc_q == PRESC_LAST);

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        acnt_d    = acnt_q;
        mt_d      = mt_q;
        mo_d      = mo_q;
        st_d      = st_q;
        so_d      = so_q;
        tick_d    = 1'b0;
        running_d = (state_q == S_RUN);
        alarm_d   = (state_q == S_ALARM);

        if (clear) begin
            state_d = S_IDLE;
            presc_d = '0;
            acnt_d  = '0;
            mt_d    = 4'd0;
            mo_d    = 4'd0;
            st_d    = 4'd0;
            so_d    = 4'd0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    presc_d = '0;
                    acnt_d  = '0;
                    if (start_stop) begin
                        if (!time_zero) begin
                            state_d = S_RUN;
                        end
                    end else begin
                        if (inc_sec) begin
                            st_d = st_inc;
                            so_d = so_inc;
                        end
                        if (inc_min) begin
                            mt_d = mt_inc;
                            mo_d = mo_inc;
                        end
                    end
                end
                S_RUN: begin
                    // a pause request wins over a coinciding second boundary; prescaler holds
                    if (start_stop) begin
                        state_d = S_PAUSE;
                    end else if (sec_boundary) begin
                        presc_d = '0;
                        mt_d    = mt_dec;
                        mo_d    = mo_dec;
                        st_d    = st_dec;
                        so_d    = so_dec;
                        tick_d  = 1'b1;
                        if (dec_zero) begin
                            state_d = S_ALARM;
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (start_stop) begin
                        state_d = S_RUN;
                    end
                end
                S_ALARM: begin
                    if (start_stop) begin
                        state_d = S_IDLE;
                        presc_d = '0;
                        acnt_d  = '0;
                    end else if (sec_boundary) begin
                        presc_d = '0;
                        if (acnt_q == ACNT_LAST) begin
                            state_d = S_IDLE;
                            acnt_d  = '0;
                        end else begin
                            acnt_d = acnt_q + 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            presc_q   <= '0;
            acnt_q    <= '0;
            mt_q      <= 4'd0;
            mo_q      <= 4'd0;
            st_q      <= 4'd0;
            so_q      <= 4'd0;
            tick_q    <= 1'b0;
            running_q <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            acnt_q    <= acnt_d;
            mt_q      <= mt_d;
            mo_q      <= mo_d;
            st_q      <= st_d;
            so_q      <= so_d;
            tick_q    <= tick_d;
            running_q <= running_d;
            alarm_q   <= alarm_d;
        end
    end

    assign min_tens = mt_q;
    assign min_ones = mo_q;
    assign sec_tens = st_q;
    assign sec_ones = so_q;
    assign running  = running_q;
    assign alarm    = alarm_q;
    assign tick     = tick_q;

endmodule

// File: tb/tb_kitchen_countdown_core.sv
// Directed bench for kitchen_countdown_core with TICK_DIV=4, ALARM_SECS=2.
module tb_kitchen_countdown_core;

    logic        clk;
    logic        rst_n;
    logic        start_stop;
    logic        clear;
    logic        inc_min;
    logic        inc_sec;
    logic [3:0]  min_tens;
    logic [3:0]  min_ones;
    logic [3:0]  sec_tens;
    logic [3:0]  sec_ones;
    logic        running;
    logic        alarm;
    logic        tick;
    logic [15:0] disp;

    int n_checks = 0;
    int n_pass   = 0;

    assign disp = {min_tens, min_ones, sec_tens, sec_ones};

    kitchen_countdown_core #(
        .TICK_DIV   (4),
        .ALARM_SECS (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_stop (start_stop),
        .clear      (clear),
        .inc_min    (inc_min),
        .inc_sec    (inc_sec),
        .min_tens   (min_tens),
        .min_ones   (min_ones),
        .sec_tens   (sec_tens),
        .sec_ones   (sec_ones),
        .running    (running),
        .alarm      (alarm),
        .tick       (tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic ss, input logic cl, input logic im, input logic isec);
        start_stop = ss;
        clear      = cl;
        inc_min    = im;
        inc_sec    = isec;
        cyc(1);
        start_stop = 1'b0;
        clear      = 1'b0;
        inc_min    = 1'b0;
        inc_sec    = 1'b0;
    endtask

    task automatic wait_tick(output int ncyc);
        ncyc = 0;
        do begin
            cyc(1);
            ncyc++;
        end while (tick !== 1'b1 && ncyc < 12);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_stop = 1'b1; clear = 1'b0; inc_min = 1'b0; inc_sec = 1'b0;
        cyc(3);
        n_checks++;
        if ({disp, running, alarm, tick} !== 19'h0) $display("FAIL reset_hold: got %h want 0", {disp, running, alarm, tick}); else n_pass++;
        start_stop = 1'b0;
        rst_n      = 1'b1;
        cyc(100);
        n_checks++;
        if (disp !== 16'h0000) $display("FAIL idle_after_reset: got %h want 0000", disp); else n_pass++;
        n_checks++;
        if ({running, alarm, tick} !== 3'b000) $display("FAIL idle_flags: got %b want 000", {running, alarm, tick}); else n_pass++;
    endtask

    task automatic test_set_wrap();
        repeat (3) pulse(0, 0, 0, 1);
        pulse(0, 0, 1, 0);
        n_checks++;
        if (disp !== 16'h0103) $display("FAIL set_0103: got %h want 0103", disp); else n_pass++;
        repeat (56) pulse(0, 0, 0, 1);
        n_checks++;
        if (disp !== 16'h0159) $display("FAIL sec_59: got %h want 0159", disp); else n_pass++;
        repeat (4) pulse(0, 0, 0, 1);
        n_checks++;
        if (disp !== 16'h0103) $display("FAIL sec_wrap: got %h want 0103", disp); else n_pass++;
        repeat (98) pulse(0, 0, 1, 0);
        n_checks++;
        if (disp !== 16'h9903) $display("FAIL min_99: got %h want 9903", disp); else n_pass++;
        repeat (2) pulse(0, 0, 1, 0);
        n_checks++;
        if (disp !== 16'h0103) $display("FAIL min_wrap: got %h want 0103", disp); else n_pass++;
        pulse(0, 0, 1, 1);
        n_checks++;
        if (disp !== 16'h0204) $display("FAIL inc_both: got %h want 0204", disp); else n_pass++;
        pulse(0, 1, 0, 0);
        n_checks++;
        if (disp !== 16'h0000) $display("FAIL clear_idle: got %h want 0000", disp); else n_pass++;
        repeat (3) pulse(0, 0, 0, 1);
        pulse(0, 0, 1, 0);
    endtask

    task automatic test_countdown();
        int n;
        pulse(1, 0, 0, 0);
        wait_tick(n);
        n_checks++;
        if (n != 4) $display("FAIL first_tick_latency: got %0d want 4", n); else n_pass++;
        n_checks++;
        if (disp !== 16'h0102) $display("FAIL first_tick_value: got %h want 0102", disp); else n_pass++;
        n_checks++;
        if (running !== 1'b1) $display("FAIL running_high: got %b want 1", running); else n_pass++;
        pulse(0, 0, 1, 1);
        n_checks++;
        if (disp !== 16'h0102) $display("FAIL inc_ignored_run: got %h want 0102", disp); else n_pass++;
        wait_tick(n);
        n_checks++;
        if (n != 3 || disp !== 16'h0101) $display("FAIL second_tick: got %0d cycles %h want 3 cycles 0101", n, disp); else n_pass++;
        wait_tick(n);
        n_checks++;
        if (disp !== 16'h0100) $display("FAIL tick_0100: got %h want 0100", disp); else n_pass++;
        wait_tick(n);
        n_checks++;
        if (disp !== 16'h0059) $display("FAIL borrow_0059: got %h want 0059", disp); else n_pass++;
    endtask

    task automatic test_pause();
        int n;
        int bad;
        cyc(2);
        pulse(1, 0, 0, 0);
        pulse(0, 0, 1, 1);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            cyc(1);
            if (disp !== 16'h0059 || tick !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL pause_frozen: got %0d bad cycles want 0", bad); else n_pass++;
        n_checks++;
        if (running !== 1'b0) $display("FAIL pause_running: got %b want 0", running); else n_pass++;
        pulse(1, 0, 0, 0);
        wait_tick(n);
        n_checks++;
        if (n != 2) $display("FAIL resume_latency: got %0d want 2", n); else n_pass++;
        n_checks++;
        if (disp !== 16'h0058) $display("FAIL resume_value: got %h want 0058", disp); else n_pass++;
    endtask

    task automatic test_run_to_alarm();
        int n;
        int bad;
        int hi;
        bad = 0;
        for (int i = 0; i < 58; i++) begin
            wait_tick(n);
            if (n != 4) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL tick_interval: got %0d bad intervals want 0", bad); else n_pass++;
        n_checks++;
        if ({disp, tick, alarm} !== 18'h2) $display("FAIL zero_tick: got %h want 00002", {disp, tick, alarm}); else n_pass++;
        cyc(1);
        n_checks++;
        if ({alarm, running, tick} !== 3'b100) $display("FAIL alarm_rise: got %b want 100", {alarm, running, tick}); else n_pass++;
        hi  = 1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (tick !== 1'b0 || disp !== 16'h0000) bad++;
            if (alarm === 1'b1) hi++;
            else break;
        end
        n_checks++;
        if (hi != 8) $display("FAIL alarm_len_countdown: got %0d want 8", hi); else n_pass++;
        n_checks++;
        if (bad != 0) $display("FAIL alarm_quiet: got %0d bad cycles want 0", bad); else n_pass++;
    endtask

    task automatic test_zero_start_clear();
        pulse(1, 0, 0, 0);
        cyc(2);
        n_checks++;
        if ({running, alarm, disp} !== 18'h0) $display("FAIL zero_start: got %h want 0", {running, alarm, disp}); else n_pass++;
        repeat (45) pulse(0, 0, 0, 1);
        n_checks++;
        if (disp !== 16'h0045) $display("FAIL set_0045: got %h want 0045", disp); else n_pass++;
        pulse(1, 0, 0, 0);
        cyc(1);
        n_checks++;
        if (running !== 1'b1) $display("FAIL run_0045: got %b want 1", running); else n_pass++;
        pulse(1, 1, 0, 0);
        cyc(1);
        n_checks++;
        if ({disp, running} !== 17'h0) $display("FAIL clear_over_ss: got %h want 0", {disp, running}); else n_pass++;
        pulse(0, 0, 0, 1);
        n_checks++;
        if (disp !== 16'h0001) $display("FAIL idle_after_clear: got %h want 0001", disp); else n_pass++;
        pulse(0, 1, 0, 0);
    endtask

    task automatic test_alarm_exit();
        int n;
        int hi;
        pulse(0, 0, 0, 1);
        pulse(1, 0, 0, 0);
        wait_tick(n);
        n_checks++;
        if (n != 4 || disp !== 16'h0000) $display("FAIL short_run: got %0d cycles %h want 4 cycles 0000", n, disp); else n_pass++;
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (alarm === 1'b1) hi++;
            else break;
        end
        n_checks++;
        if (hi != 8) $display("FAIL alarm_len: got %0d want 8", hi); else n_pass++;
        n_checks++;
        if ({running, disp} !== 17'h0) $display("FAIL after_alarm: got %h want 0", {running, disp}); else n_pass++;

        pulse(0, 0, 0, 1);
        pulse(1, 0, 0, 0);
        wait_tick(n);
        cyc(3);
        n_checks++;
        if (alarm !== 1'b1) $display("FAIL alarm_cycle3: got %b want 1", alarm); else n_pass++;
        pulse(1, 0, 0, 0);
        pulse(0, 0, 0, 1);
        n_checks++;
        if ({alarm, disp} !== 17'h0001) $display("FAIL alarm_ack: got %h want 00001", {alarm, disp}); else n_pass++;
        pulse(0, 1, 0, 0);
    endtask

    task automatic test_async_reset();
        repeat (30) pulse(0, 0, 0, 1);
        pulse(1, 0, 0, 0);
        cyc(6);
        n_checks++;
        if (running !== 1'b1 || disp !== 16'h0029) $display("FAIL pre_reset: got %b %h want 1 0029", running, disp); else n_pass++;
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({disp, running, alarm, tick} !== 19'h0) $display("FAIL async_reset: got %h want 0", {disp, running, alarm, tick}); else n_pass++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(20);
        n_checks++;
        if ({disp, running, alarm} !== 18'h0) $display("FAIL post_reset_idle: got %h want 0", {disp, running, alarm}); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_set_wrap();
        test_countdown();
        test_pause();
        test_run_to_alarm();
        test_zero_start_clear();
        test_alarm_exit();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/kitchen_countdown_core.md
Name: kitchen_countdown_core

Overview:
Consumes the free-running system clock, prescales it to a one-second enable, and runs the kitchen-timer countdown FSM. Time is held as four BCD digits (MM:SS) for the display driver. Raises an alarm at 00:00. Control inputs arrive as single-cycle pulses that are already debounced and synchronised upstream.

Parameters:
TICK_DIV, 50000000, clock cycles per one-second tick (>=2; benches use 4)
ALARM_SECS, 30, seconds the alarm stays asserted before auto-return to IDLE (>=1)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start_stop  input  1  1-cycle pulse: start / pause / resume / acknowledge alarm
clear  input  1  1-cycle pulse: abort and zero the time
inc_min  input  1  1-cycle pulse: +1 minute (IDLE only)
inc_sec  input  1  1-cycle pulse: +1 second (IDLE only)
min_tens  output  4  BCD minutes tens
min_ones  output  4  BCD minutes ones
sec_tens  output  4  BCD seconds tens (0-5)
sec_ones  output  4  BCD seconds ones
running  output  1  high in RUN
alarm  output  1  high in ALARM
tick  output  1  1-cycle pulse on each one-second decrement in RUN

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n. All state is registered on the clk rising edge.
- rst_n low: state=IDLE, all digits 0, prescaler=0, alarm-seconds counter=0, running=0, alarm=0, tick=0. This applies immediately, including mid-count.
- Prescaler: counts 0..TICK_DIV-1 only in RUN and ALARM, and holds its value in PAUSE. It is zeroed on every entry to IDLE and on IDLE->RUN. A second boundary is prescaler==TICK_DIV-1, after which the prescaler wraps to 0.
- Input priority per cycle: clear > start_stop > inc_min/inc_sec. inc_min and inc_sec in the same cycle both apply.
- IDLE:
  - inc_sec: seconds 00->59 then wrap to 00, with no carry into minutes.
  - inc_min: minutes 00->99 then wrap to 00.
  - start_stop with time != 00:00 goes to RUN. With time == 00:00 it is ignored (stays IDLE).
- RUN:
  - On each second boundary, decrement MM:SS by one and pulse tick for that cycle.
  - Borrow: sec_ones 0->9 with sec_tens-1; SS 00->59 with MM-1.
  - If the decrement result is 00:00, the next state is ALARM. alarm goes high the cycle after the tick that shows 00:00.
  - start_stop goes to PAUSE. inc_* are ignored.
- PAUSE: digits and prescaler are frozen. start_stop goes to RUN. inc_* are ignored.
- ALARM:
  - Digits stay at 00:00 and alarm=1.
  - Counts ALARM_SECS second boundaries, then goes to IDLE automatically.
  - start_stop goes to IDLE early.
  - tick does not pulse in ALARM.
- clear in any state: next state IDLE, digits 00:00, prescaler and alarm counter zeroed.
- running and alarm are registered decodes of the state. tick is registered.
- BCD digits never hold values >9, and sec_tens never holds a value >5.

Test Plan:
- Reset: hold rst_n=0 with start_stop pulsed -> all outputs 0. Release, then no input for 100 cycles -> still IDLE, 00:00.
- Set/wrap: 3x inc_sec, 1x inc_min -> 01:03. Then 60x inc_sec -> 01:03 (wraps). Then 100x inc_min -> 01:03. Issue inc_min+inc_sec together -> 02:04.
- Countdown (TICK_DIV=4) from 01:03:
  - start_stop -> running=1; first tick 4 cycles later -> 01:02.
  - After 63 ticks: 00:00, then alarm=1 one cycle later and running=0.
  - Check 01:00 -> 00:59 on the borrow tick.
- Pause: pause after 2 prescaler counts -> digits frozen for 50 cycles and tick=0. Resume -> next tick arrives 2 cycles later (prescaler held).
- Zero start and clear: start_stop at 00:00 -> stays IDLE, running=0. In RUN at 00:45, clear together with start_stop -> IDLE, 00:00, running=0.
- Alarm exit (TICK_DIV=4, ALARM_SECS=2): alarm stays high exactly 8 cycles, then IDLE. Repeat with start_stop in the alarm's 3rd cycle -> IDLE next cycle. Assert rst_n mid-RUN -> outputs 0 immediately, without waiting for a clk edge.
